// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle between the fetch unit, instruction memory and decode.
// master: the fetch unit. slave: the memory/decode side that feeds it.
interface instruction_fetch_if #(
    parameter int COUNT_W = 16
);
    logic [31:0]        pc;
    logic [31:0]        instruction;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        ir;
    logic [31:0]        ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               fault;
    logic [COUNT_W-1:0] fetch_count;

    modport master (
        output pc,
        output ir,
        output ir_pc,
        output ir_valid,
        output fault,
        output fetch_count,
        input  instruction,
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  ir_ready
    );

    modport slave (
        input  pc,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        input  fault,
        input  fetch_count,
        output instruction,
        output stall,
        output redirect,
        output redirect_pc,
        output ir_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC, captures the word the memory returns
// for it into ir/ir_pc, and hands it to decode with a valid/ready handshake.
// Supports stall, branch/jump redirect and a sticky misaligned-target fault.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    // Low address bits are forced to zero so pc[1:0] can never be non-zero.
    localparam logic [31:0]        RESET_PC_W = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0]        PC_STEP    = 32'h0000_0004;
    localparam logic [COUNT_W-1:0] CNT_ZERO   = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_MAX    = {COUNT_W{1'b1}};

    // A target is usable only when it is word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
        logic [COUNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        pc_r;
    logic [31:0]        pc_nxt_s;
    logic [31:0]        ir_r;
    logic [31:0]        ir_nxt_s;
    logic [31:0]        ir_pc_r;
    logic [31:0]        ir_pc_nxt_s;
    logic               ir_valid_r;
    logic               ir_valid_nxt_s;
    logic               fault_r;
    logic               fault_nxt_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_nxt_s;

    logic               redirect_ok_s;
    logic               redirect_bad_s;
    logic               capture_s;
    logic               accept_only_s;

    // Decode the per-cycle fetch decision; redirect outranks everything else.
    always_comb begin
        redirect_ok_s  = bus.redirect && is_aligned(bus.redirect_pc);
        redirect_bad_s = bus.redirect && !is_aligned(bus.redirect_pc);
        capture_s      = !bus.redirect && !bus.stall && (!ir_valid_r || bus.ir_ready);
        accept_only_s  = !bus.redirect && bus.stall && ir_valid_r && bus.ir_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE lasts one cycle; a misaligned redirect traps in FAULT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect_bad_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_bad_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values for each state.
    always_comb begin
        pc_nxt_s       = pc_r;
        ir_nxt_s       = ir_r;
        ir_pc_nxt_s    = ir_pc_r;
        ir_valid_nxt_s = ir_valid_r;
        fault_nxt_s    = fault_r;
        count_nxt_s    = count_r;
        case (state_r)
            ST_IDLE: begin
                // Memory is still settling on the reset PC: never capture here.
                if (redirect_ok_s) begin
                    pc_nxt_s       = {bus.redirect_pc[31:2], 2'b00};
                    ir_valid_nxt_s = 1'b0;
                end else if (redirect_bad_s) begin
                    fault_nxt_s    = 1'b1;
                    ir_valid_nxt_s = 1'b0;
                end else begin
                    pc_nxt_s       = pc_r;
                end
            end
            ST_FETCH: begin
                if (redirect_ok_s) begin
                    // Flush: the word currently on the memory port is dropped.
                    pc_nxt_s       = {bus.redirect_pc[31:2], 2'b00};
                    ir_valid_nxt_s = 1'b0;
                end else if (redirect_bad_s) begin
                    fault_nxt_s    = 1'b1;
                    ir_valid_nxt_s = 1'b0;
                end else if (capture_s) begin
                    ir_nxt_s       = bus.instruction;
                    ir_pc_nxt_s    = pc_r;
                    ir_valid_nxt_s = 1'b1;
                    pc_nxt_s       = pc_r + PC_STEP;
                    count_nxt_s    = sat_inc(count_r);
                end else if (accept_only_s) begin
                    // Decode took ir while stalled: drain it, keep the PC.
                    ir_valid_nxt_s = 1'b0;
                end else begin
                    pc_nxt_s       = pc_r;
                end
            end
            ST_FAULT: begin
                // Frozen until reset; all inputs ignored.
                pc_nxt_s = pc_r;
            end
            default: begin
                pc_nxt_s = pc_r;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r       <= RESET_PC_W;
            ir_r       <= 32'h0000_0000;
            ir_pc_r    <= 32'h0000_0000;
            ir_valid_r <= 1'b0;
            fault_r    <= 1'b0;
            count_r    <= CNT_ZERO;
        end else begin
            pc_r       <= pc_nxt_s;
            ir_r       <= ir_nxt_s;
            ir_pc_r    <= ir_pc_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
            fault_r    <= fault_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.ir          = ir_r;
    assign bus.ir_pc       = ir_pc_r;
    assign bus.ir_valid    = ir_valid_r;
    assign bus.fault       = fault_r;
    assign bus.fetch_count = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, backpressure, stall,
// redirect, misaligned-redirect fault, and PC wrap with a saturating counter.
module tb_instruction_fetch;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   tests_run;
    int   tests_failed;

    instruction_fetch_if #(.COUNT_W(16)) if_a ();
    instruction_fetch_if #(.COUNT_W(2))  if_b ();

    // Instruction memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    assign if_a.instruction = mem_word(if_a.pc);
    assign if_b.instruction = mem_word(if_b.pc);

    instruction_fetch #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .COUNT_W(2)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wrap_pc [5];
        logic [31:0] wrap_cnt [5];
        tests_run    = 0;
        tests_failed = 0;
        wrap_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        wrap_cnt = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.stall = 1'b0; if_a.redirect = 1'b0; if_a.redirect_pc = 32'h0; if_a.ir_ready = 1'b1;
        if_b.stall = 1'b0; if_b.redirect = 1'b0; if_b.redirect_pc = 32'h0; if_b.ir_ready = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_pc", if_a.pc, 32'h0);
        check("rst_ir", if_a.ir, 32'h0);
        check("rst_ir_pc", if_a.ir_pc, 32'h0);
        check("rst_valid", {31'b0, if_a.ir_valid}, 32'h0);
        check("rst_fault", {31'b0, if_a.fault}, 32'h0);
        check("rst_count", {16'b0, if_a.fetch_count}, 32'h0);

        // Release; one IDLE cycle with no capture
        rst_a = 1'b1;
        tick();
        check("idle_pc", if_a.pc, 32'h0);
        check("idle_valid", {31'b0, if_a.ir_valid}, 32'h0);

        // Sequential fetch 0,4,8,C,10,14
        for (int i = 0; i < 6; i++) begin
            tick();
            check("seq_ir_pc", if_a.ir_pc, 32'(4 * i));
            check("seq_ir", if_a.ir, mem_word(32'(4 * i)));
            check("seq_valid", {31'b0, if_a.ir_valid}, 32'h1);
        end
        check("seq_count", {16'b0, if_a.fetch_count}, 32'd6);
        check("seq_pc", if_a.pc, 32'h18);

        // Redirect to 8 to set up backpressure
        if_a.redirect = 1'b1; if_a.redirect_pc = 32'h8;
        tick();
        check("rd8_pc", if_a.pc, 32'h8);
        check("rd8_valid", {31'b0, if_a.ir_valid}, 32'h0);
        check("rd8_count", {16'b0, if_a.fetch_count}, 32'd6);
        if_a.redirect = 1'b0;
        tick();
        check("rd8_ir_pc", if_a.ir_pc, 32'h8);
        check("rd8_count2", {16'b0, if_a.fetch_count}, 32'd7);

        // Backpressure for 3 cycles
        if_a.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ir_pc", if_a.ir_pc, 32'h8);
            check("bp_ir", if_a.ir, mem_word(32'h8));
            check("bp_pc", if_a.pc, 32'hC);
            check("bp_count", {16'b0, if_a.fetch_count}, 32'd7);
            check("bp_valid", {31'b0, if_a.ir_valid}, 32'h1);
        end
        if_a.ir_ready = 1'b1;
        tick();
        check("bp_resume_ir_pc", if_a.ir_pc, 32'hC);
        check("bp_resume_pc", if_a.pc, 32'h10);
        check("bp_resume_count", {16'b0, if_a.fetch_count}, 32'd8);

        // Stall for 2 cycles with ir_ready high
        if_a.stall = 1'b1;
        tick();
        check("st1_valid", {31'b0, if_a.ir_valid}, 32'h0);
        check("st1_pc", if_a.pc, 32'h10);
        tick();
        check("st2_valid", {31'b0, if_a.ir_valid}, 32'h0);
        check("st2_pc", if_a.pc, 32'h10);
        check("st2_count", {16'b0, if_a.fetch_count}, 32'd8);
        if_a.stall = 1'b0;
        tick();
        check("st_resume_ir_pc", if_a.ir_pc, 32'h10);
        check("st_resume_ir", if_a.ir, mem_word(32'h10));
        check("st_resume_count", {16'b0, if_a.fetch_count}, 32'd9);

        // Bring ir_pc to 4, then redirect to 0x40
        if_a.redirect = 1'b1; if_a.redirect_pc = 32'h4;
        tick();
        if_a.redirect = 1'b0;
        tick();
        check("pre_rd_ir_pc", if_a.ir_pc, 32'h4);
        check("pre_rd_pc", if_a.pc, 32'h8);
        if_a.redirect = 1'b1; if_a.redirect_pc = 32'h40;
        tick();
        check("rd_pc", if_a.pc, 32'h40);
        check("rd_valid", {31'b0, if_a.ir_valid}, 32'h0);
        check("rd_no8", if_a.ir_pc, 32'h4);
        check("rd_count", {16'b0, if_a.fetch_count}, 32'd10);
        if_a.redirect = 1'b0;
        tick();
        check("rd_ir_pc", if_a.ir_pc, 32'h40);
        check("rd_ir", if_a.ir, mem_word(32'h40));
        check("rd_valid2", {31'b0, if_a.ir_valid}, 32'h1);
        check("rd_count2", {16'b0, if_a.fetch_count}, 32'd11);

        // Misaligned redirect -> sticky fault
        if_a.redirect = 1'b1; if_a.redirect_pc = 32'h42;
        tick();
        check("flt_fault", {31'b0, if_a.fault}, 32'h1);
        check("flt_valid", {31'b0, if_a.ir_valid}, 32'h0);
        check("flt_pc", if_a.pc, 32'h44);
        for (int i = 0; i < 5; i++) begin
            if_a.redirect    = i[0];
            if_a.redirect_pc = 32'h100 + 32'(i * 4);
            if_a.ir_ready    = ~i[0];
            if_a.stall       = i[1];
            tick();
            check("flt_hold_pc", if_a.pc, 32'h44);
            check("flt_hold_fault", {31'b0, if_a.fault}, 32'h1);
            check("flt_hold_valid", {31'b0, if_a.ir_valid}, 32'h0);
            check("flt_hold_count", {16'b0, if_a.fetch_count}, 32'd11);
        end

        // Asynchronous reset clears the fault between clock edges
        rst_a = 1'b0;
        #1;
        check("async_fault", {31'b0, if_a.fault}, 32'h0);
        check("async_pc", if_a.pc, 32'h0);
        check("async_count", {16'b0, if_a.fetch_count}, 32'h0);

        // Wrap and saturation on the second instance
        tick();
        rst_b = 1'b1;
        tick();
        check("wrap_idle_pc", if_b.pc, 32'hFFFF_FFF8);
        check("wrap_idle_valid", {31'b0, if_b.ir_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wrap_ir_pc", if_b.ir_pc, wrap_pc[i]);
            check("wrap_ir", if_b.ir, mem_word(wrap_pc[i]));
            check("wrap_count", {30'b0, if_b.fetch_count}, wrap_cnt[i]);
        end
        check("wrap_pc", if_b.pc, 32'h0000_000C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
